// File: rtl/qsort_pkg.sv
// Shared types and constants for the quicksort stream host and its word buffer.
package qsort_pkg;

    localparam int N_DEF    = 8;
    localparam int W_DEF    = 32;
    localparam int INIT_CYC = 2;

    typedef enum logic [2:0] {
        FILL,
        GAP1,
        LOAD,
        INIT,
        WAIT,
        GAP2,
        DRAIN,
        SEND
    } state_t;

endpackage

// File: rtl/qsort_word_buf.sv
// N x W register file: one synchronous write port, one combinational read port.
module qsort_word_buf
    import qsort_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] words [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_word
            logic [W-1:0] word_reg;

            always_ff @(posedge clk) begin
                if (we && waddr == AW'(gi)) begin
                    word_reg <= wdata;
                end
            end

            assign words[gi] = word_reg;
        end
    endgenerate

    assign rdata = words[raddr];

endmodule

// File: rtl/qsort_stream_host.sv
// Host-side master for the quicksort core: stream in N words, load, launch,
// wait for completion, drain the sorted words and stream them out with an order check.
module qsort_stream_host
    import qsort_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int W       = W_DEF,
    parameter int TIMEOUT = 4096
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic         out_last,
    output logic         sorted_ok,
    output logic         err_timeout,
    output logic         busy,
    output logic [W-1:0] sort_xin,
    output logic         sort_read,
    output logic         sort_write,
    output logic         sort_init,
    input  logic [W-1:0] sort_xout,
    input  logic         sort_done
);

    localparam int AW = $clog2(N);
    localparam int IW = $clog2(N) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    state_t         state_reg, state_next;
    logic [IW-1:0]  idx_reg, idx_next;
    logic [TW-1:0]  tmo_reg, tmo_next;
    logic           seen_low_reg, seen_low_next;
    logic           dv_reg;
    logic [AW-1:0]  cap_addr_reg;
    logic [W-1:0]   last_cap_reg;
    logic           ok_run_reg, ok_run_next;
    logic           sorted_ok_reg;

    logic           in_fire, out_fire, timeout_hit;
    logic           buf_we;
    logic [AW-1:0]  buf_waddr;
    logic [W-1:0]   buf_wdata, buf_rdata;

    qsort_word_buf #(.N(N), .W(W)) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (buf_wdata),
        .raddr (idx_reg[AW-1:0]),
        .rdata (buf_rdata)
    );

    // dv_reg marks the cycle after a drain strobe, when the sorter's registered xout is valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= FILL;
            idx_reg       <= '0;
            tmo_reg       <= '0;
            seen_low_reg  <= 1'b0;
            dv_reg        <= 1'b0;
            cap_addr_reg  <= '0;
            last_cap_reg  <= '0;
            ok_run_reg    <= 1'b0;
            sorted_ok_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            tmo_reg      <= tmo_next;
            seen_low_reg <= seen_low_next;
            dv_reg       <= (state_reg == DRAIN);
            cap_addr_reg <= idx_reg[AW-1:0];
            if (dv_reg) begin
                last_cap_reg <= sort_xout;
            end
            if (state_reg == GAP2) begin
                ok_run_reg <= 1'b1;
            end else if (dv_reg) begin
                ok_run_reg <= ok_run_next;
            end
            if (state_reg == SEND && dv_reg) begin
                sorted_ok_reg <= ok_run_next;
            end
        end
    end

    // The order check runs on words as they land in the buffer, so it is final before out_valid rises
    assign ok_run_next = ok_run_reg & ~((cap_addr_reg != '0) && (sort_xout < last_cap_reg));

    assign in_fire     = (state_reg == FILL) && in_valid;
    assign out_fire    = out_valid && out_ready;
    assign timeout_hit = (state_reg == WAIT) && (tmo_reg == TMO_LAST) && !(seen_low_reg && sort_done);

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        tmo_next      = tmo_reg;
        seen_low_next = seen_low_reg;
        case (state_reg)
            FILL: begin
                if (in_fire) begin
                    if (idx_reg == LAST_IDX) begin
                        idx_next   = '0;
                        state_next = GAP1;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            GAP1: state_next = LOAD;
            LOAD: begin
                if (idx_reg == LAST_IDX) begin
                    idx_next   = '0;
                    state_next = INIT;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            INIT: begin
                if (idx_reg == INIT_LAST) begin
                    idx_next      = '0;
                    tmo_next      = '0;
                    seen_low_next = 1'b0;
                    state_next    = WAIT;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            WAIT: begin
                tmo_next = tmo_reg + 1'b1;
                if (!sort_done) begin
                    seen_low_next = 1'b1;
                end
                // done is only trusted after it has been seen low, masking the stale pre-launch level
                if (seen_low_reg && sort_done) begin
                    state_next = GAP2;
                end else if (timeout_hit) begin
                    state_next = FILL;
                end
            end
            GAP2: state_next = DRAIN;
            DRAIN: begin
                if (idx_reg == LAST_IDX) begin
                    idx_next   = '0;
                    state_next = SEND;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            SEND: begin
                if (out_fire) begin
                    if (idx_reg == LAST_IDX) begin
                        idx_next   = '0;
                        state_next = FILL;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        in_ready    = (state_reg == FILL);
        busy        = (state_reg != FILL);
        sort_read   = (state_reg == LOAD);
        sort_write  = (state_reg == DRAIN);
        sort_init   = (state_reg == INIT);
        sort_xin    = (state_reg == LOAD) ? buf_rdata : '0;
        out_valid   = (state_reg == SEND) && !dv_reg;
        out_data    = out_valid ? buf_rdata : '0;
        out_last    = out_valid && (idx_reg == LAST_IDX);
        sorted_ok   = sorted_ok_reg;
        err_timeout = timeout_hit;
        buf_we      = in_fire | dv_reg;
        buf_waddr   = in_fire ? idx_reg[AW-1:0] : cap_addr_reg;
        buf_wdata   = in_fire ? in_data : sort_xout;
    end

endmodule
